// File: rtl/lfsr_decrypt_engine.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_decrypt_engine
//  Description : Memory-master decrypter. Reads preamble length, taps and seed
//                from the parameter words, then streams the LFSR-encrypted
//                ciphertext out of dmem one byte per cycle, strips the
//                preamble and writes plaintext back to the bottom of dmem.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_decrypt_engine #(
    parameter int WIDTH   = 8,
    parameter int LFSR_W  = 7,
    parameter int CT_BASE = 64,
    parameter int CT_LEN  = 60,
    parameter int PT_MAX  = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic             wen,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_PLEN = 3'd1;
    localparam logic [2:0] S_RD_TAPS = 3'd2;
    localparam logic [2:0] S_RD_SEED = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Parameter word locations sit just below the ciphertext block.
    localparam logic [WIDTH-1:0] ADDR_PLEN = WIDTH'(61);
    localparam logic [WIDTH-1:0] ADDR_TAPS = WIDTH'(62);
    localparam logic [WIDTH-1:0] ADDR_SEED = WIDTH'(63);
    localparam logic [WIDTH-1:0] C_CT_BASE = WIDTH'(CT_BASE);
    localparam logic [WIDTH-1:0] C_CT_LEN  = WIDTH'(CT_LEN);
    localparam logic [WIDTH-1:0] C_LAST    = WIDTH'(CT_LEN - 1);
    localparam logic [WIDTH-1:0] C_PT_MAX  = WIDTH'(PT_MAX);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [WIDTH-1:0]  plen;
    logic [WIDTH-1:0]  idx;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] taps;

    logic [WIDTH-1:0]  pt_off;
    logic              write_ok;
    logic [LFSR_W-1:0] pt_bits;

    // Offset into the plaintext area; only meaningful once idx >= plen.
    assign pt_off   = idx - plen;
    assign write_ok = (idx >= plen) && (pt_off < C_PT_MAX);
    assign pt_bits  = rdata[LFSR_W-1:0] ^ lfsr;

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing: three parameter reads, CT_LEN run cycles, done.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_RD_PLEN;
            S_RD_PLEN: state_next = S_RD_TAPS;
            S_RD_TAPS: state_next = S_RD_SEED;
            S_RD_SEED: state_next = S_RUN;
            S_RUN:     if (idx == C_LAST) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath registers: captured parameters, keystream LFSR and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plen <= '0;
            taps <= '0;
            lfsr <= '0;
            idx  <= '0;
        end else begin
            case (state)
                S_RD_PLEN: plen <= (rdata > C_CT_LEN) ? C_CT_LEN : rdata;
                S_RD_TAPS: taps <= rdata[LFSR_W-1:0];
                S_RD_SEED: begin
                    lfsr <= rdata[LFSR_W-1:0];
                    idx  <= '0;
                end
                S_RUN: begin
                    // Keystream advances on every byte, preamble included.
                    lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & taps)};
                    if (idx != C_LAST) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-port and status outputs decoded from the current state.
    always_comb begin
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        raddr = '0;
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state)
            S_RD_PLEN: raddr = ADDR_PLEN;
            S_RD_TAPS: raddr = ADDR_TAPS;
            S_RD_SEED: raddr = ADDR_SEED;
            S_RUN: begin
                raddr = C_CT_BASE + idx;
                if (write_ok) begin
                    wen   = 1'b1;
                    waddr = pt_off;
                    wdata = WIDTH'(pt_bits);
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_decrypt_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_decrypt_engine
//  Description : Self-checking bench for lfsr_decrypt_engine with a dmem
//                model and a behavioural keystream reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_decrypt_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, wen;
    logic [7:0] raddr, rdata, waddr, wdata;

    logic [7:0] mem [0:255];
    logic [7:0] ct  [0:59];
    logic [7:0] exp_pt [0:47];
    int         exp_wr;

    int errors = 0;
    int checks = 0;

    int wr_cnt, bad_wr, done_cnt;
    int done_cyc, busy_at_done, busy_after;

    lfsr_decrypt_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .raddr (raddr),
        .rdata (rdata),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata)
    );

    always #5 clk = ~clk;

    assign rdata = mem[raddr];

    // dmem write port plus write/done bookkeeping.
    always @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
            wr_cnt = wr_cnt + 1;
            if (waddr > 8'd47) bad_wr = bad_wr + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plaintext the decrypter must produce for the ciphertext in ct[].
    task automatic ref_model(input int plen_raw, input logic [6:0] taps, input logic [6:0] seed);
        int p;
        logic [6:0] ks;
        p = (plen_raw > 60) ? 60 : plen_raw;
        ks = seed;
        exp_wr = 0;
        for (int k = 0; k < 48; k++) exp_pt[k] = 8'hEE;
        for (int i = 0; i < 60; i++) begin
            if (i >= p && (i - p) < 48) begin
                exp_pt[i-p] = {1'b0, ct[i][6:0] ^ ks};
                exp_wr++;
            end
            ks = {ks[5:0], ^(ks & taps)};
        end
    endtask

    task automatic load_mem(input int plen_raw, input logic [7:0] taps, input logic [7:0] seed);
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        for (int a = 0; a < 48; a++) mem[a] = 8'hEE;
        mem[61] = 8'(plen_raw);
        mem[62] = taps;
        mem[63] = seed;
        for (int i = 0; i < 60; i++) mem[64+i] = ct[i];
    endtask

    // Issue start, watch 70 cycles; optional second start and mid-op reset.
    task automatic run_op(input int restart_at, input int reset_at);
        wr_cnt = 0; bad_wr = 0; done_cnt = 0;
        done_cyc = -1; busy_at_done = 0; busy_after = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            if (done && done_cyc < 0) begin
                done_cyc = cyc;
                busy_at_done = int'(busy);
            end
            if (cyc == 65) busy_after = int'(busy);
            start = (cyc == restart_at);
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_wen", int'(wen), 0);
                check_eq("rst_busy", int'(busy), 0);
                check_eq("rst_done", int'(done), 0);
                check_eq("rst_raddr", int'(raddr), 0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag);
        check_eq({tag, "_done_cyc"}, done_cyc, 64);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_busy_done"}, busy_at_done, 1);
        check_eq({tag, "_busy_idle"}, busy_after, 0);
        check_eq({tag, "_writes"}, wr_cnt, exp_wr);
        check_eq({tag, "_outside"}, bad_wr, 0);
        for (int k = 0; k < 48; k++) check_eq({tag, "_pt"}, int'(mem[k]), int'(exp_pt[k]));
    endtask

    task automatic rand_case(input string tag, input int plen_raw, input int restart_at);
        logic [7:0] taps, seed;
        taps = 8'($urandom);
        seed = 8'($urandom);
        for (int i = 0; i < 60; i++) ct[i] = 8'($urandom);
        load_mem(plen_raw, taps, seed);
        ref_model(plen_raw, taps[6:0], seed[6:0]);
        run_op(restart_at, 0);
        check_run(tag);
    endtask

    initial begin
        logic [7:0] msg [0:47];
        logic [6:0] ks, rt_taps, rt_seed;
        int         p;

        #12;
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_wen", int'(wen), 0);
        check_eq("reset_raddr", int'(raddr), 0);
        check_eq("reset_waddr", int'(waddr), 0);
        check_eq("reset_wdata", int'(wdata), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Pass-through: zero keystream, preamble of 10.
        for (int i = 0; i < 60; i++) ct[i] = 8'($urandom);
        ct[10] = 8'hC1;
        load_mem(10, 8'h00, 8'h00);
        ref_model(10, 7'h00, 7'h00);
        run_op(0, 0);
        check_run("pass");
        check_eq("pass_mem0", int'(mem[0]), 8'h41);

        // Seed XOR with fixed keystream 0x7F, 0x7E.
        for (int i = 0; i < 60; i++) ct[i] = 8'($urandom);
        ct[0] = 8'h5F; ct[1] = 8'h3E;
        load_mem(0, 8'h00, 8'h7F);
        ref_model(0, 7'h00, 7'h7F);
        run_op(0, 0);
        check_run("seed");
        check_eq("seed_mem0", int'(mem[0]), 8'h20);
        check_eq("seed_mem1", int'(mem[1]), 8'h40);

        // Round trip through an encrypt-path model.
        for (int r = 0; r < 3; r++) begin
            p = 7 + int'($urandom_range(0, 5));
            rt_taps = 7'($urandom);
            rt_seed = 7'($urandom);
            for (int k = 0; k < 48; k++) msg[k] = 8'($urandom_range(32, 126));
            ks = rt_seed;
            for (int i = 0; i < 60; i++) begin
                logic [7:0] plain;
                if (i < p) plain = 8'h20;
                else if (i - p < 48) plain = msg[i-p];
                else plain = 8'h20;
                ct[i] = {1'($urandom), plain[6:0] ^ ks};
                ks = {ks[5:0], ^(ks & rt_taps)};
            end
            load_mem(p, {1'b0, rt_taps}, {1'b0, rt_seed});
            run_op(0, 0);
            check_eq("rt_outside", bad_wr, 0);
            check_eq("rt_done_cnt", done_cnt, 1);
            for (int k = 0; k < 48; k++) check_eq("rt_msg", int'(mem[k]), int'(msg[k]));
        end

        // Saturation: preamble longer than the ciphertext.
        rand_case("sat", 8'hFF, 0);
        check_eq("sat_wr", wr_cnt, 0);
        rand_case("sat60", 60, 0);

        // Random preamble lengths, including the clipping region.
        for (int r = 0; r < 4; r++) rand_case("rand", int'($urandom_range(0, 70)), 0);

        // Start while busy is ignored.
        rand_case("restart", 20, 20);

        // Mid-op reset, then a clean run.
        for (int i = 0; i < 60; i++) ct[i] = 8'($urandom);
        load_mem(5, 8'h55, 8'h33);
        run_op(0, 30);
        p = wr_cnt;
        repeat (3) @(negedge clk);
        check_eq("rst_no_writes", wr_cnt, p);
        check_eq("rst_idle_busy", int'(busy), 0);
        rand_case("after_rst", 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
